// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised single-clock FIFO.
//  - clog2()          : ceiling log2, used to size pointers and the fill count
//  - FIFO_AW(depth)   : address width macro for a given depth
//  - fifo_params_ok() : elaboration-time legality check of the FIFO parameters
`define FIFO_AW(depth) (sync_fifo_param_pkg::clog2(depth))

package sync_fifo_param_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

  // DEPTH must be a power of two >= 4, AF_LEVEL in 1..DEPTH, AE_LEVEL in 0..DEPTH-1.
  function automatic bit fifo_params_ok(input int width, input int depth,
                                        input int af_level, input int ae_level);
    bit ok;
    ok = (width >= 32'sd1) &&
         (depth >= 32'sd4) &&
         ((depth & (depth - 32'sd1)) == 32'sd0) &&
         (af_level >= 32'sd1) && (af_level <= depth) &&
         (ae_level >= 32'sd0) && (ae_level <= depth - 32'sd1);
    return ok;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM for the FIFO storage: one synchronous write port and
// one asynchronous read port. The asynchronous read lets the show-ahead mode
// present the head word with no latency (maps onto distributed/LUT RAM).
// Ports:
//  clk   in  1      write clock
//  we    in  1      write enable
//  waddr in  AW     write address
//  wdata in  WIDTH  write data
//  raddr in  AW     read address
//  rdata out WIDTH  read data, combinational from raddr
module fifo_dpram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact fill count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// selectable read mode (show-ahead or registered output).
// Ports:
//  clk          in   1      clock, all state changes on the rising edge
//  sclr         in   1      synchronous active-high clear, overrides requests
//  wrreq        in   1      write request, accepted when not full
//  data         in   WIDTH  write data
//  rdreq        in   1      read request, accepted when not empty
//  q            out  WIDTH  read data (head word, or registered read result)
//  usedw        out  AW+1   number of stored entries, 0..DEPTH
//  empty        out  1      usedw == 0
//  full         out  1      usedw == DEPTH
//  almost_empty out  1      usedw <= AE_LEVEL
//  almost_full  out  1      usedw >= AF_LEVEL
//  overflow     out  1      sticky, write requested while full
//  underflow    out  1      sticky, read requested while empty
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_LEVEL  = 28,
  parameter int AE_LEVEL  = 4,
  parameter int SHOWAHEAD = 1,
  localparam int AW       = `FIFO_AW(DEPTH)
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic [AW:0]      usedw,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  if (!fifo_params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_error
    $error("sync_fifo_param: illegal parameters WIDTH=%0d DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           WIDTH, DEPTH, AF_LEVEL, AE_LEVEL);
  end

  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_THRES = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_THRES = (AW+1)'(AE_LEVEL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      usedw_s;
  logic             full_s;
  logic             empty_s;
  logic             do_write_s;
  logic             do_read_s;
  logic             overflow_r;
  logic             underflow_r;
  logic [WIDTH-1:0] ram_rdata_s;

  assign usedw_s = wr_ptr_r - rd_ptr_r;
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);

  // Acceptance uses the pre-edge flags; a clear suppresses both ports.
  assign do_write_s = wrreq & ~full_s  & ~sclr;
  assign do_read_s  = rdreq & ~empty_s & ~sclr;

  // Write and read pointer counters.
  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_write_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_read_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Sticky error flags; only a clear resets them.
  always_ff @(posedge clk) begin
    if (sclr) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  | (wrreq & full_s);
      underflow_r <= underflow_r | (rdreq & empty_s);
    end
  end

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (do_write_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (data),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  if (SHOWAHEAD != 0) begin : g_showahead
    // Head word straight from the asynchronous RAM read port.
    assign q = ram_rdata_s;
  end else begin : g_registered
    logic [WIDTH-1:0] q_r;

    // Registered read data; holds across idle and rejected reads.
    always_ff @(posedge clk) begin
      if (sclr) begin
        q_r <= '0;
      end else if (do_read_s) begin
        q_r <= ram_rdata_s;
      end
    end

    assign q = q_r;
  end

  assign usedw        = usedw_s;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_empty = (usedw_s <= AE_THRES);
  assign almost_full  = (usedw_s >= AF_THRES);
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: two instances (show-ahead and registered
// output) receive identical stimulus. A queue-based reference model tracks
// contents and sticky flags; expected read words are pushed into per-instance
// scoreboards when a read is issued and a negedge monitor pops and compares.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AF    = 28;
  localparam int AE    = 4;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             sclr = 1'b0;
  logic             wrreq = 1'b0;
  logic             rdreq = 1'b0;
  logic [WIDTH-1:0] data = '0;

  logic [WIDTH-1:0] q1, q0;
  logic [AW:0]      usedw1, usedw0;
  logic             empty1, full1, ae1, af1, ovf1, unf1;
  logic             empty0, full0, ae0, af0, ovf0, unf0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(1)) u_sa1 (
    .clk(clk), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq), .q(q1),
    .usedw(usedw1), .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1),
    .overflow(ovf1), .underflow(unf1));

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(0)) u_sa0 (
    .clk(clk), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq), .q(q0),
    .usedw(usedw0), .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0),
    .overflow(ovf0), .underflow(unf0));

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a plain queue, sticky flags as bits.
  logic [WIDTH-1:0] model_q[$];
  bit               model_ovf = 1'b0;
  bit               model_unf = 1'b0;

  // Scoreboards of words each instance must deliver, in order.
  logic [WIDTH-1:0] exp1_q[$];
  logic [WIDTH-1:0] exp0_q[$];

  bit               started   = 1'b0;
  bit               rd_pend0  = 1'b0;
  bit               clr_pend0 = 1'b1;
  logic [WIDTH-1:0] q0_exp    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, record expectations, advance the model at the edge.
  task automatic cycle(input bit s, input bit w, input bit r, input logic [WIDTH-1:0] d);
    int  pre;
    bit  acc_rd, acc_wr;
    sclr  = s;
    wrreq = w;
    rdreq = r;
    data  = d;
    pre    = model_q.size();
    acc_rd = !s && r && (pre > 0);
    acc_wr = !s && w && (pre < DEPTH);
    if (acc_rd) begin
      exp1_q.push_back(model_q[0]);
      exp0_q.push_back(model_q[0]);
    end
    @(posedge clk);
    if (s) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      if (w && pre == DEPTH) model_ovf = 1'b1;
      if (r && pre == 0)     model_unf = 1'b1;
      if (acc_rd) void'(model_q.pop_front());
      if (acc_wr) model_q.push_back(d);
    end
    #1;
  endtask

  // Monitor: compares status against the model and read data against the scoreboards.
  always @(negedge clk) begin
    int               n;
    logic [WIDTH-1:0] e;
    if (started) begin
      n = model_q.size();
      check("usedw_sa1",      32'(usedw1), n);
      check("usedw_sa0",      32'(usedw0), n);
      check("empty_sa1",      32'(empty1), 32'(n == 0));
      check("empty_sa0",      32'(empty0), 32'(n == 0));
      check("full_sa1",       32'(full1),  32'(n == DEPTH));
      check("full_sa0",       32'(full0),  32'(n == DEPTH));
      check("almost_empty",   32'(ae1),    32'(n <= AE));
      check("almost_empty0",  32'(ae0),    32'(n <= AE));
      check("almost_full",    32'(af1),    32'(n >= AF));
      check("almost_full0",   32'(af0),    32'(n >= AF));
      check("overflow_sa1",   32'(ovf1),   32'(model_ovf));
      check("overflow_sa0",   32'(ovf0),   32'(model_ovf));
      check("underflow_sa1",  32'(unf1),   32'(model_unf));
      check("underflow_sa0",  32'(unf0),   32'(model_unf));

      // Show-ahead: the word on q before the read edge is the one consumed.
      if (rdreq && !sclr && n > 0) begin
        if (exp1_q.size() == 0) begin
          check("sb1_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp1_q.pop_front();
          check("q_showahead", 32'(q1), 32'(e));
        end
      end

      // Registered: q updates after a read edge, clears on sclr, otherwise holds.
      if (clr_pend0) begin
        q0_exp = '0;
      end else if (rd_pend0) begin
        if (exp0_q.size() == 0) begin
          check("sb0_nonempty", 32'd0, 32'd1);
        end else begin
          q0_exp = exp0_q.pop_front();
        end
      end
      check("q_registered", 32'(q0), 32'(q0_exp));
      rd_pend0  = rdreq && !sclr && (n > 0);
      clr_pend0 = sclr;
    end
  end

  initial begin
    int pw, pr;

    // Reset.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    started = 1'b1;

    // 1: fill with 0x00..0x1F, extra write while full, then drain.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i));
    cycle(1'b0, 1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // 2: read while empty, then clear.
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // 3: read+write while full, then read+write while empty.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
    cycle(1'b0, 1'b1, 1'b1, 8'h77);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h42);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // 4: streaming at half fill; 100 writes wrap the pointers several times.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // 5: registered-mode hold behaviour.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, 1'b0, 8'h3C);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // 6: clear with 20 entries and a concurrent write; new data only afterwards.
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
    cycle(1'b1, 1'b1, 1'b0, 8'hEE);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h11);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // Randomised phases with varying write/read pressure and rare clears.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        2:       begin pw = 60; pr = 60; end
        default: begin pw = 95; pr = 10; end
      endcase
      for (int i = 0; i < 200; i++) begin
        cycle(($urandom_range(0, 149) == 0),
              ($urandom_range(0, 99) < pw),
              ($urandom_range(0, 99) < pr),
              8'($urandom));
      end
    end

    // Drain and let the registered-mode monitor consume its last word.
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("sb1_drained", 32'(exp1_q.size()), 32'd0);
    check("sb0_drained", 32'(exp0_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
